data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port data memory between the CPU MEM-stage (port cpu) and the debug/program loader (port dbg).
- Grants at most one access per cycle and drives the memory's address, write data, write enable and read enable.
- Registers the read data back to the winning requester one cycle later.
- Provides a debug lock for multi-word bursts, with starvation limits on both sides.

Parameters:
- DATA_BITS, 32, data word width.
- ADDR_BITS, 32, address width.
- MAX_WAIT, 8, cycles a requesting dbg may be refused before it is force-granted.
- LOCK_MAX, 16, maximum consecutive locked dbg grants before one forced CPU slot.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; hold with cpu_we/addr/wdata stable until cpu_gnt.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_BITS  word address.
- cpu_wdata  in  DATA_BITS  write data.
- cpu_gnt  out  1  combinational grant; access commits at this clock edge.
- cpu_rvalid  out  1  one-cycle pulse, read data valid.
- cpu_rdata  out  DATA_BITS  registered read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_BITS/DATA_BITS  same meaning as the cpu_* inputs.
- dbg_lock  in  1  request to keep ownership after this grant.
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_BITS  same meaning as the cpu_* outputs.
- mem_address  out  ADDR_BITS  to memory address.
- mem_writeData  out  DATA_BITS  to memory write data.
- mem_memWrite  out  1  to memory write enable.
- mem_memRead  out  1  to memory read enable.
- mem_readData  in  DATA_BITS  from memory read data (combinational read).

Behaviour:
- The clock port is named clk. Reset is the synchronous, active-high input reset; it is sampled only on the rising edge of clk.
- Reset values:
  - state=ARB, wait_cnt=0, lock_cnt=0, last_gnt=dbg (CPU wins the first tie).
  - rvalid both 0, rdata both 0.
  - Reset mid-burst drops the lock; an in-flight read produces no rvalid.
- Grant is combinational from state, requests and counters. At most one gnt is high per cycle; no gnt while reset=1.
- Memory drive:
  - No grant: mem_memWrite=0, mem_memRead=0, mem_address=0, mem_writeData=0.
  - Grant: addr/wdata are muxed from the winner; mem_memWrite=winner_we; mem_memRead=!winner_we.
- Latency:
  - Write commits at the grant edge.
  - Read: mem_readData is captured into the winner's rdata at the grant edge; rvalid=1 the next cycle only.
  - Back-to-back grants give back-to-back rvalid.
  - Writes never raise rvalid.
- State ARB (fixed priority; CPU wins over dbg):
  - wait_cnt increments each cycle dbg_req=1 and dbg_gnt=0; it clears on dbg_gnt or when dbg_req=0.
  - When wait_cnt==MAX_WAIT-1, dbg wins the next arbitration regardless of cpu_req.
  - dbg granted with dbg_lock=1 -> LOCKED, lock_cnt=1.
- State LOCKED:
  - Only dbg may be granted; cpu_gnt=0. lock_cnt increments per dbg grant.
  - dbg granted with dbg_lock=0 -> ARB.
  - dbg_req=0 with dbg_lock=0 -> ARB.
  - lock_cnt==LOCK_MAX -> FORCE.
- State FORCE:
  - Exactly one cycle; dbg_gnt=0.
  - cpu_gnt=cpu_req (a slot with no CPU request is wasted).
  - Next state: LOCKED with lock_cnt=0 if dbg_lock=1, else ARB.
- Simultaneous events:
  - A forced dbg grant and cpu_req in the same cycle: dbg wins and the CPU stalls.
  - FORCE has priority over a lock request.
- Address and data are passed through unchanged; no width arithmetic.

Optional Feature:
- Macro: DATA_MEM_ARB_RR_EN.
- Defined: in ARB, ties go to the requester not equal to last_gnt (round robin). last_gnt updates on every grant. wait_cnt/MAX_WAIT logic is still present but cannot trigger.
- Undefined: fixed CPU priority as above; last_gnt is not implemented.

Decomposition:
- Shared package data_mem_pkg holds:
  - State enum ARB/LOCKED/FORCE.
  - Requester ID constants REQ_CPU=0, REQ_DBG=1.
  - Default DATA_BITS/ADDR_BITS.
- One natural sub-module, data_mem_arb_grant: the combinational grant decode (state, reqs, counters, last_gnt -> gnt vector).
- The top level keeps the state register, counters, memory mux and read-return registers.

Test Plan:
- Reset for 2 cycles with both reqs high -> no gnt, mem_memWrite=0, mem_memRead=0. First cycle after reset: cpu_gnt=1.
- cpu write 0xDEADBEEF to addr 0x10, then cpu read addr 0x10 -> the read's cpu_rvalid=1 one cycle after its grant, cpu_rdata=0xDEADBEEF, dbg_rvalid=0.
- cpu_req and dbg_req held high continuously (no RR) -> dbg_gnt on exactly the 8th contending cycle, then cpu resumes; with RR, grants alternate cpu,dbg,cpu,...
- dbg burst of 20 writes with dbg_lock=1 and cpu_req=1 throughout -> 16 dbg grants, 1 cpu grant (FORCE), then 4 dbg grants; lock release returns to ARB.
- reset asserted in the cycle after a dbg read grant inside LOCKED -> dbg_rvalid stays 0, state=ARB, next contended grant goes to cpu.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory arbiter.
// Optional round-robin tie break is enabled with DATA_MEM_ARB_RR_EN.
package data_mem_pkg;
    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCKED = 2'd1,
        FORCE  = 2'd2
    } arb_state_t;

    // Requester IDs double as bit positions in the grant vector
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int DEF_DATA_BITS = 32;
    localparam int DEF_ADDR_BITS = 32;
endpackage

// File: rtl/data_mem_arb_grant.sv
// Combinational grant decode: state, requests and counters -> one-hot grant.
// With DATA_MEM_ARB_RR_EN defined, ARB ties go to the requester that did
// not win last; otherwise the CPU wins ties.
module data_mem_arb_grant
    import data_mem_pkg::*;
#(
    parameter int MAX_WAIT  = 8,
    parameter int WAIT_BITS = 4
) (
    input  logic                 i_reset,
    input  arb_state_t           i_state,
    input  logic                 i_cpu_req,
    input  logic                 i_dbg_req,
    input  logic [WAIT_BITS-1:0] i_wait_cnt,
`ifdef DATA_MEM_ARB_RR_EN
    input  logic                 i_last_gnt,
`endif
    output logic [1:0]           o_gnt
);

    logic w_dbg_starved;
    assign w_dbg_starved = i_dbg_req && (i_wait_cnt == WAIT_BITS'(MAX_WAIT - 1));

    // Pick at most one winner; nothing is granted while reset is high
    always_comb begin
        o_gnt = 2'b00;
        if (!i_reset) begin
            case (i_state)
                ARB: begin
                    if (w_dbg_starved) begin
                        o_gnt[REQ_DBG] = 1'b1;
                    end else if (i_cpu_req && i_dbg_req) begin
`ifdef DATA_MEM_ARB_RR_EN
                        if (i_last_gnt == REQ_CPU) o_gnt[REQ_DBG] = 1'b1;
                        else                       o_gnt[REQ_CPU] = 1'b1;
`else
                        o_gnt[REQ_CPU] = 1'b1;
`endif
                    end else begin
                        o_gnt[REQ_CPU] = i_cpu_req;
                        o_gnt[REQ_DBG] = i_dbg_req;
                    end
                end
                LOCKED:  o_gnt[REQ_DBG] = i_dbg_req;
                // One guaranteed CPU slot; wasted if the CPU is idle
                FORCE:   o_gnt[REQ_CPU] = i_cpu_req;
                default: o_gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester (CPU / debug loader) arbiter for a single-port data memory.
// Holds the arbitration FSM, starvation counters, memory mux and the
// registered read-return path. DATA_MEM_ARB_RR_EN enables round-robin ties.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int MAX_WAIT  = 8,
    parameter int LOCK_MAX  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [DATA_BITS-1:0] cpu_wdata,
    output logic                 cpu_gnt,
    output logic                 cpu_rvalid,
    output logic [DATA_BITS-1:0] cpu_rdata,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    input  logic [DATA_BITS-1:0] dbg_wdata,
    input  logic                 dbg_lock,
    output logic                 dbg_gnt,
    output logic                 dbg_rvalid,
    output logic [DATA_BITS-1:0] dbg_rdata,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic [DATA_BITS-1:0] mem_writeData,
    output logic                 mem_memWrite,
    output logic                 mem_memRead,
    input  logic [DATA_BITS-1:0] mem_readData
);

    localparam int WAIT_BITS = $clog2(MAX_WAIT + 1);
    localparam int LOCK_BITS = $clog2(LOCK_MAX + 1);

    arb_state_t           r_state;
    logic [WAIT_BITS-1:0] r_wait_cnt;
    logic [LOCK_BITS-1:0] r_lock_cnt;
    logic                 r_cpu_rvalid, r_dbg_rvalid;
    logic [DATA_BITS-1:0] r_cpu_rdata, r_dbg_rdata;
    logic [1:0]           w_gnt;
    logic [LOCK_BITS-1:0] w_lock_nxt;
    logic                 w_wait_max;
`ifdef DATA_MEM_ARB_RR_EN
    logic                 r_last_gnt;
`endif

    data_mem_arb_grant #(
        .MAX_WAIT  (MAX_WAIT),
        .WAIT_BITS (WAIT_BITS)
    ) u_grant (
        .i_reset    (reset),
        .i_state    (r_state),
        .i_cpu_req  (cpu_req),
        .i_dbg_req  (dbg_req),
        .i_wait_cnt (r_wait_cnt),
`ifdef DATA_MEM_ARB_RR_EN
        .i_last_gnt (r_last_gnt),
`endif
        .o_gnt      (w_gnt)
    );

    assign cpu_gnt    = w_gnt[REQ_CPU];
    assign dbg_gnt    = w_gnt[REQ_DBG];
    assign w_lock_nxt = r_lock_cnt + LOCK_BITS'(1);
    assign w_wait_max = (r_wait_cnt == WAIT_BITS'(MAX_WAIT - 1));

    // A read in flight when reset arrives must not surface as a valid pulse
    assign cpu_rvalid = r_cpu_rvalid & ~reset;
    assign dbg_rvalid = r_dbg_rvalid & ~reset;
    assign cpu_rdata  = r_cpu_rdata;
    assign dbg_rdata  = r_dbg_rdata;

    // Drive the memory from the winner; idle bus is all zeros
    always_comb begin
        mem_address   = '0;
        mem_writeData = '0;
        mem_memWrite  = 1'b0;
        mem_memRead   = 1'b0;
        if (w_gnt[REQ_CPU]) begin
            mem_address   = cpu_addr;
            mem_writeData = cpu_wdata;
            mem_memWrite  = cpu_we;
            mem_memRead   = ~cpu_we;
        end else if (w_gnt[REQ_DBG]) begin
            mem_address   = dbg_addr;
            mem_writeData = dbg_wdata;
            mem_memWrite  = dbg_we;
            mem_memRead   = ~dbg_we;
        end
    end

    // Arbitration FSM with dbg starvation counter and lock-burst counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ARB;
            r_wait_cnt <= '0;
            r_lock_cnt <= '0;
        end else begin
            // Saturating: only ARB can force a grant, so the cap is never hit there
            if (dbg_req && !w_gnt[REQ_DBG]) begin
                if (!w_wait_max) r_wait_cnt <= r_wait_cnt + WAIT_BITS'(1);
            end else begin
                r_wait_cnt <= '0;
            end

            case (r_state)
                ARB: begin
                    if (w_gnt[REQ_DBG] && dbg_lock) begin
                        r_state    <= LOCKED;
                        r_lock_cnt <= LOCK_BITS'(1);
                    end
                end
                LOCKED: begin
                    if (w_gnt[REQ_DBG]) begin
                        if (!dbg_lock) begin
                            r_state    <= ARB;
                            r_lock_cnt <= '0;
                        end else begin
                            // Reaching the cap overrides the lock request
                            if (w_lock_nxt == LOCK_BITS'(LOCK_MAX)) r_state <= FORCE;
                            r_lock_cnt <= w_lock_nxt;
                        end
                    end else if (!dbg_req && !dbg_lock) begin
                        r_state    <= ARB;
                        r_lock_cnt <= '0;
                    end
                end
                FORCE: begin
                    r_lock_cnt <= '0;
                    r_state    <= dbg_lock ? LOCKED : ARB;
                end
                default: begin
                    r_state    <= ARB;
                    r_lock_cnt <= '0;
                end
            endcase
        end
    end

    // Capture read data for the winner at the grant edge; rvalid pulses next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= w_gnt[REQ_CPU] && !cpu_we;
            r_dbg_rvalid <= w_gnt[REQ_DBG] && !dbg_we;
            if (w_gnt[REQ_CPU] && !cpu_we) r_cpu_rdata <= mem_readData;
            if (w_gnt[REQ_DBG] && !dbg_we) r_dbg_rdata <= mem_readData;
        end
    end

`ifdef DATA_MEM_ARB_RR_EN
    // Remember the last winner for the round-robin tie break
    always_ff @(posedge clk) begin
        if (reset)               r_last_gnt <= REQ_DBG;
        else if (w_gnt[REQ_CPU]) r_last_gnt <= REQ_CPU;
        else if (w_gnt[REQ_DBG]) r_last_gnt <= REQ_DBG;
    end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter; honours DATA_MEM_ARB_RR_EN.
module tb_data_mem_arbiter;
    localparam int MW = 8;
    localparam int LM = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic [31:0] mem_address, mem_writeData, mem_readData;
    logic        mem_memWrite, mem_memRead;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_arr [0:31];

    always #5 clk = ~clk;

    // Behavioural single-port memory with combinational read
    always @(posedge clk) if (mem_memWrite) mem_arr[mem_address[4:0]] <= mem_writeData;
    assign mem_readData = mem_arr[mem_address[4:0]];

    data_mem_arbiter #(
        .DATA_BITS(32), .ADDR_BITS(32), .MAX_WAIT(MW), .LOCK_MAX(LM)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead), .mem_readData(mem_readData)
    );

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1; idle_inputs();
        @(negedge clk); @(negedge clk); reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1; cpu_req = 1; dbg_req = 1; cpu_we = 1; dbg_we = 0;
        cpu_addr = 32'h4; dbg_addr = 32'h8;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (cpu_gnt !== 1'b0) begin failures++; $display("FAIL reset_cpu_gnt got=%b exp=0", cpu_gnt); end
            checks++; if (dbg_gnt !== 1'b0) begin failures++; $display("FAIL reset_dbg_gnt got=%b exp=0", dbg_gnt); end
            checks++; if (mem_memWrite !== 1'b0 || mem_memRead !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b%b exp=00", mem_memWrite, mem_memRead); end
            @(negedge clk);
        end
        #1;
        checks++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", cpu_rvalid, dbg_rvalid); end
        checks++; if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0", cpu_rdata, dbg_rdata); end
        reset = 0;
        #1;
        checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin failures++; $display("FAIL reset_first_gnt got=%b%b exp=10", cpu_gnt, dbg_gnt); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_write_read();
        do_reset();
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%b exp=1", cpu_gnt); end
        checks++; if (mem_memWrite !== 1'b1 || mem_memRead !== 1'b0 || mem_address !== 32'h10 || mem_writeData !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wr_mem got=we%b re%b a%h d%h exp=we1 re0 a10 dDEADBEEF", mem_memWrite, mem_memRead, mem_address, mem_writeData); end
        @(negedge clk);
        cpu_we = 0; cpu_wdata = 32'h0;
        #1;
        checks++; if (cpu_gnt !== 1'b1 || mem_memRead !== 1'b1 || mem_memWrite !== 1'b0) begin failures++; $display("FAIL rd_gnt got=g%b re%b we%b exp=g1 re1 we0", cpu_gnt, mem_memRead, mem_memWrite); end
        checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL wr_no_rvalid got=%b exp=0", cpu_rvalid); end
        @(negedge clk);
        cpu_req = 0;
        #1;
        checks++; if (cpu_rvalid !== 1'b1) begin failures++; $display("FAIL rd_rvalid got=%b exp=1", cpu_rvalid); end
        checks++; if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_rdata got=%h exp=deadbeef", cpu_rdata); end
        checks++; if (dbg_rvalid !== 1'b0) begin failures++; $display("FAIL rd_dbg_rvalid got=%b exp=0", dbg_rvalid); end
        checks++; if (mem_address !== 32'h0 || mem_memRead !== 1'b0) begin failures++; $display("FAIL idle_mem got=a%h re%b exp=a0 re0", mem_address, mem_memRead); end
        @(negedge clk); #1;
        checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL rd_pulse got=%b exp=0", cpu_rvalid); end
    endtask

    task automatic test_contention();
        bit exp_dbg;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            cpu_req = 1; cpu_we = 0; cpu_addr = 32'h1;
            dbg_req = 1; dbg_we = 0; dbg_addr = 32'h2; dbg_lock = 0;
            #1;
`ifdef DATA_MEM_ARB_RR_EN
            exp_dbg = (k % 2 == 0);
`else
            exp_dbg = (k % MW == 0);
`endif
            checks++; if (dbg_gnt !== exp_dbg || cpu_gnt !== !exp_dbg) begin
                failures++; $display("FAIL contention_k%0d got=cpu%b dbg%b exp=cpu%b dbg%b", k, cpu_gnt, dbg_gnt, !exp_dbg, exp_dbg); end
        end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_lock_burst();
        int done = 0;
        int cyc = 0;
        bit exp_dbg;
        do_reset();
        while (done < 20 && cyc < 40) begin
            @(negedge clk);
            cpu_req = (cyc > 0); cpu_we = 0; cpu_addr = 32'h1F;
            dbg_req = 1; dbg_we = 1; dbg_addr = 32'(done); dbg_wdata = 32'hA000 + 32'(done);
            dbg_lock = (done < 19);
            #1;
            exp_dbg = (cyc != LM);
            checks++; if (dbg_gnt !== exp_dbg || cpu_gnt !== !exp_dbg) begin
                failures++; $display("FAIL burst_c%0d got=cpu%b dbg%b exp=cpu%b dbg%b", cyc, cpu_gnt, dbg_gnt, !exp_dbg, exp_dbg); end
            if (dbg_gnt === 1'b1) done++;
            cyc++;
        end
        checks++; if (done != 20 || cyc != 21) begin failures++; $display("FAIL burst_len got=grants%0d cycles%0d exp=grants20 cycles21", done, cyc); end
        @(negedge clk);
        dbg_req = 0; dbg_lock = 0; cpu_req = 1;
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin failures++; $display("FAIL burst_release got=%b exp=1", cpu_gnt); end
        @(negedge clk); idle_inputs();
        #1;
        for (int i = 0; i < 20; i++) begin
            checks++; if (mem_arr[i] !== 32'hA000 + 32'(i)) begin failures++; $display("FAIL burst_mem%0d got=%h exp=%h", i, mem_arr[i], 32'hA000 + 32'(i)); end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        @(negedge clk);
        dbg_req = 1; dbg_we = 1; dbg_lock = 1; dbg_addr = 32'h3; dbg_wdata = 32'h5555;
        #1;
        checks++; if (dbg_gnt !== 1'b1) begin failures++; $display("FAIL mid_first got=%b exp=1", dbg_gnt); end
        @(negedge clk);
        dbg_we = 0; cpu_req = 1;
        #1;
        checks++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin failures++; $display("FAIL mid_locked_rd got=cpu%b dbg%b exp=cpu0 dbg1", cpu_gnt, dbg_gnt); end
        @(negedge clk);
        reset = 1;
        #1;
        checks++; if (dbg_rvalid !== 1'b0) begin failures++; $display("FAIL mid_rvalid_rst got=%b exp=0", dbg_rvalid); end
        checks++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin failures++; $display("FAIL mid_gnt_rst got=%b%b exp=00", cpu_gnt, dbg_gnt); end
        @(negedge clk);
        reset = 0; cpu_req = 1; dbg_req = 1; dbg_lock = 1;
        #1;
        checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin failures++; $display("FAIL mid_after got=cpu%b dbg%b exp=cpu1 dbg0", cpu_gnt, dbg_gnt); end
        checks++; if (dbg_rvalid !== 1'b0) begin failures++; $display("FAIL mid_rvalid_after got=%b exp=0", dbg_rvalid); end
        @(negedge clk); idle_inputs();
    endtask

    // Random traffic against a rule-level model of ownership and refusals
    task automatic test_random();
        logic [31:0] gold [0:31];
        int  refused = 0, burst = 0;
        bit  locked = 0, slot = 0, last_dbg = 1;
        bit  ec, ed, ew, er, ecv = 0, edv = 0;
        logic [31:0] ecd = 0, edd = 0, ea, ewd;
        int  lock_pct, dreq_pct;
        do_reset();
        for (int i = 0; i < 32; i++) gold[i] = mem_arr[i];
        for (int n = 0; n < 500; n++) begin
            lock_pct = (n < 250) ? 6 : 10;
            dreq_pct = (n < 250) ? 5 : 8;
            @(negedge clk);
            cpu_req = ($urandom_range(0, 9) < 6); cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 32'($urandom_range(0, 31)); cpu_wdata = $urandom;
            dbg_req = ($urandom_range(0, 9) < dreq_pct); dbg_we = 1'($urandom_range(0, 1));
            dbg_addr = 32'($urandom_range(0, 31)); dbg_wdata = $urandom;
            dbg_lock = ($urandom_range(0, 10) < lock_pct);
            #1;
            ec = 0; ed = 0;
            if (slot) ec = cpu_req;
            else if (locked) ed = dbg_req;
            else if (dbg_req && refused == MW - 1) ed = 1;
            else if (cpu_req && dbg_req) begin
`ifdef DATA_MEM_ARB_RR_EN
                if (last_dbg) ec = 1; else ed = 1;
`else
                ec = 1;
`endif
            end else begin ec = cpu_req; ed = dbg_req; end
            ea  = ec ? cpu_addr  : (ed ? dbg_addr  : 32'h0);
            ewd = ec ? cpu_wdata : (ed ? dbg_wdata : 32'h0);
            ew  = ec ? cpu_we : (ed ? dbg_we : 1'b0);
            er  = (ec || ed) && !ew;
            checks++; if (cpu_gnt !== ec || dbg_gnt !== ed) begin failures++; $display("FAIL rnd_gnt n%0d got=cpu%b dbg%b exp=cpu%b dbg%b", n, cpu_gnt, dbg_gnt, ec, ed); end
            checks++; if (mem_address !== ea || mem_writeData !== ewd || mem_memWrite !== ew || mem_memRead !== er) begin
                failures++; $display("FAIL rnd_mem n%0d got=a%h d%h we%b re%b exp=a%h d%h we%b re%b", n, mem_address, mem_writeData, mem_memWrite, mem_memRead, ea, ewd, ew, er); end
            checks++; if (cpu_rvalid !== ecv || dbg_rvalid !== edv) begin failures++; $display("FAIL rnd_rvalid n%0d got=%b%b exp=%b%b", n, cpu_rvalid, dbg_rvalid, ecv, edv); end
            if (ecv) begin checks++; if (cpu_rdata !== ecd) begin failures++; $display("FAIL rnd_cpu_rdata n%0d got=%h exp=%h", n, cpu_rdata, ecd); end end
            if (edv) begin checks++; if (dbg_rdata !== edd) begin failures++; $display("FAIL rnd_dbg_rdata n%0d got=%h exp=%h", n, dbg_rdata, edd); end end
            // Advance the model past this clock edge
            ecv = ec && !cpu_we; if (ecv) ecd = gold[cpu_addr[4:0]];
            edv = ed && !dbg_we; if (edv) edd = gold[dbg_addr[4:0]];
            if (ew) gold[ea[4:0]] = ewd;
            if (slot) begin
                slot = 0; locked = dbg_lock; burst = 0;
            end else if (locked) begin
                if (ed) begin
                    burst++;
                    if (!dbg_lock) locked = 0;
                    else if (burst == LM) begin locked = 0; slot = 1; end
                end else if (!dbg_req && !dbg_lock) locked = 0;
            end else if (ed && dbg_lock) begin
                locked = 1; burst = 1;
            end
            refused = (dbg_req && !ed) ? refused + 1 : 0;
            if (ec) last_dbg = 0; else if (ed) last_dbg = 1;
        end
        @(negedge clk); idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_contention();
        test_lock_burst();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
